// File: rtl/dv_test_end_pkg.sv
// Shared types and constants for the end-of-test controller.
package dv_test_end_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] DEF_PASS_CODE = 32'hC001C0DE;
  localparam logic [31:0] DEF_FAIL_CODE = 32'hDEADBEEF;

  typedef logic [63:0] cyc_t;

  // FAIL_CODE is named explicitly, but any code other than PASS also fails.
  function automatic logic code_fails(input logic [31:0] code,
                                      input logic [31:0] pass_code,
                                      input logic [31:0] fail_code);
    return (code == fail_code) || (code != pass_code);
  endfunction

endpackage

// File: rtl/dv_test_end_if.sv
// Per-requester report handshake: valid/ready plus a 32-bit status code.
interface dv_test_end_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    rpt_valid;
  logic [NUM_REQ*32-1:0] rpt_code;
  logic [NUM_REQ-1:0]    rpt_ready;

  modport master (output rpt_valid, output rpt_code, input rpt_ready);
  modport slave  (input rpt_valid, input rpt_code, output rpt_ready);
endinterface

// File: rtl/dv_rr_arb.sv
// Round-robin arbiter: one-hot grant to the lowest valid index at or after
// the pointer; the pointer moves past the winner when advance is high.
module dv_rr_arb #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] idx;
  logic          found;

  // Rotating priority search starting at the pointer.
  always_comb begin
    grant = '0;
    gidx  = ptr;
    idx   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      if (32'(ptr) + off >= NUM_REQ) idx = PW'(32'(ptr) + off - NUM_REQ);
      else                           idx = PW'(32'(ptr) + off);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

  // Pointer register: winner + 1 modulo NUM_REQ on acceptance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/dv_test_end_ctrl.sv
// End-of-test controller: arbitrates requester reports, tracks done/fail,
// runs a kickable watchdog, drains, then holds test_end/test_fail.
module dv_test_end_ctrl
  import dv_test_end_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned TIMEOUT      = 0,
  parameter int unsigned DRAIN_CYCLES = 100,
  parameter bit          FAIL_FAST    = 1'b1,
  parameter logic [31:0] PASS_CODE    = DEF_PASS_CODE,
  parameter logic [31:0] FAIL_CODE    = DEF_FAIL_CODE
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [NUM_REQ-1:0] req_en_mask,
  dv_test_end_if.slave       rpt,
  input  logic               heartbeat,
  output logic               test_end,
  output logic               test_fail,
  output logic               timed_out,
  output logic [NUM_REQ-1:0] done_vec,
  output logic [NUM_REQ-1:0] fail_vec,
  output cyc_t               end_cycle,
  output logic [1:0]         state
);

  localparam logic [31:0] DRAIN_LAST = (DRAIN_CYCLES == 0) ? 32'd0 : 32'(DRAIN_CYCLES - 1);

  state_t             st, st_nxt;
  cyc_t               cyc_cnt, end_nxt;
  logic [31:0]        wd_cnt, wd_nxt, drain_cnt, drain_nxt;
  logic [NUM_REQ-1:0] arb_valid, grant, done_nxt, fail_nxt;
  logic               acc, complete, expire, to_nxt, verdict, verdict_nxt;

  assign arb_valid     = (st == RUN) ? rpt.rpt_valid : '0;
  assign rpt.rpt_ready = grant;
  assign acc           = |grant;

  dv_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .valid   (arb_valid),
    .advance (acc),
    .grant   (grant)
  );

  assign test_end  = (st == DONE);
  assign test_fail = test_end & verdict;
  assign state     = st;

  // Next-state, vector update, watchdog and drain counting.
  always_comb begin
    st_nxt      = st;
    done_nxt    = done_vec;
    fail_nxt    = fail_vec;
    wd_nxt      = wd_cnt;
    drain_nxt   = drain_cnt;
    to_nxt      = timed_out;
    verdict_nxt = verdict;
    end_nxt     = end_cycle;
    complete    = 1'b0;
    expire      = 1'b0;
    case (st)
      IDLE: begin
        if (start) begin
          st_nxt = RUN;
          wd_nxt = TIMEOUT;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (grant[i] && req_en_mask[i]) begin
            done_nxt[i] = 1'b1;
            if (code_fails(rpt.rpt_code[32*i +: 32], PASS_CODE, FAIL_CODE))
              fail_nxt[i] = 1'b1;
          end
        end
        complete = ((|req_en_mask) && (&(done_nxt | ~req_en_mask)))
                 || (FAIL_FAST && (|fail_nxt));
        // A kick counts as this cycle's tick, so expiry lands TIMEOUT
        // cycles after the most recent kick (or after RUN entry).
        if (TIMEOUT != 0) begin
          wd_nxt = heartbeat ? 32'(TIMEOUT - 1) : wd_cnt - 32'd1;
          expire = (wd_nxt == 32'd0);
        end
        if (complete || expire) begin
          to_nxt      = expire && !complete;
          verdict_nxt = (|fail_nxt) || to_nxt;
          end_nxt     = cyc_cnt + 64'd1;
          drain_nxt   = '0;
          st_nxt      = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) st_nxt = DONE;
        else                         drain_nxt = drain_cnt + 32'd1;
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st <= IDLE;
    else       st <= st_nxt;
  end

  // Datapath registers: counters, sticky vectors, verdict and snapshot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_cnt   <= '0;
      wd_cnt    <= '0;
      drain_cnt <= '0;
      done_vec  <= '0;
      fail_vec  <= '0;
      timed_out <= 1'b0;
      verdict   <= 1'b0;
      end_cycle <= '0;
    end else begin
      cyc_cnt   <= cyc_cnt + 64'd1;
      wd_cnt    <= wd_nxt;
      drain_cnt <= drain_nxt;
      done_vec  <= done_nxt;
      fail_vec  <= fail_nxt;
      timed_out <= to_nxt;
      verdict   <= verdict_nxt;
      end_cycle <= end_nxt;
    end
  end

endmodule
